// File: rtl/spi_mem_bridge.sv
// rtl/spi_mem_bridge.sv - Core load/store port bridged to a serial SRAM over SPI mode 0
module spi_mem_bridge #(
  parameter int ADDR_BYTES = 3,
  parameter int CLK_DIV    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [2:0]  option,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        memory_response,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int         HDR_BITS = 8 + 8 * ADDR_BYTES;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

  state_t      state_q;
  logic [63:0] sh_q;        // outgoing frame, MSB is the bit currently on MOSI
  logic [31:0] rx_q;        // incoming data bits, first received bit ends up highest
  logic [7:0]  div_q;       // clk cycles spent in the current SCK half-period
  logic [6:0]  bit_q;       // bits fully clocked out so far
  logic [6:0]  bits_q;      // total bits in this frame
  logic [2:0]  opt_q;
  logic        load_q;
  logic [31:0] read_data_q;
  logic        resp_q;
  logic        busy_q;
  logic        cs_n_q;
  logic        sck_q;

  logic [31:0] addr_al;
  logic [31:0] wswap;
  logic [63:0] frame_d;
  logic [6:0]  bits_d;
  logic [15:0] half_le;
  logic [31:0] rdata_d;
  logic        sx;

  // Build the frame to launch at accept and the load result to commit at the end
  always_comb begin
    addr_al = address << (32 - 8 * ADDR_BYTES);
    wswap   = {write_data[7:0], write_data[15:8], write_data[23:16], write_data[31:24]};
    frame_d = '0;
    frame_d[63:56] = memory_write ? 8'h02 : 8'h03;
    frame_d[55:24] = addr_al;
    // Data bytes follow the address; lower address bits in addr_al are zero, so overwrite is safe
    frame_d[55-8*ADDR_BYTES -: 32] = memory_write ? wswap : 32'h0;
    case (option[1:0])
      2'b00:   bits_d = 7'(HDR_BITS + 8);
      2'b01:   bits_d = 7'(HDR_BITS + 16);
      default: bits_d = 7'(HDR_BITS + 32);
    endcase
    // Last byte received is the most significant, so rx_q[7] is the sign bit for LB and LH
    sx      = ~opt_q[2] & rx_q[7];
    half_le = {rx_q[7:0], rx_q[15:8]};
    case (opt_q[1:0])
      2'b00:   rdata_d = {{24{sx}}, rx_q[7:0]};
      2'b01:   rdata_d = {{16{sx}}, half_le};
      default: rdata_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
    endcase
  end

  // Transaction FSM: accept, shift the frame out on SCK falls, sample MISO on SCK rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sh_q        <= '0;
      rx_q        <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      bits_q      <= '0;
      opt_q       <= '0;
      load_q      <= 1'b0;
      read_data_q <= '0;
      resp_q      <= 1'b0;
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (memory_read || memory_write) begin
            state_q <= S_CMD;
            sh_q    <= frame_d;
            bits_q  <= bits_d;
            opt_q   <= option;
            load_q  <= ~memory_write;
            bit_q   <= '0;
            div_q   <= '0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_CMD, S_ADDR, S_DATA: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            sck_q <= ~sck_q;
            if (!sck_q) begin
              if (state_q == S_DATA) rx_q <= {rx_q[30:0], spi_miso};
            end else begin
              sh_q  <= {sh_q[62:0], 1'b0};
              bit_q <= bit_q + 7'd1;
              if (bit_q == bits_q - 7'd1) begin
                state_q <= S_DONE;
                sh_q    <= '0;
                cs_n_q  <= 1'b1;
                resp_q  <= 1'b1;
                if (load_q) read_data_q <= rdata_d;
              end else if (bit_q == 7'd7) begin
                state_q <= S_ADDR;
              end else if (bit_q == 7'(HDR_BITS - 1)) begin
                state_q <= S_DATA;
              end
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign read_data       = read_data_q;
  assign memory_response = resp_q;
  assign busy            = busy_q;
  assign spi_cs_n        = cs_n_q;
  assign spi_sck         = sck_q;
  assign spi_mosi        = sh_q[63];

endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb/tb_spi_mem_bridge.sv - directed vector bench for spi_mem_bridge with a serial SRAM model
module tb_spi_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mr [2];
  logic        mw [2];
  logic [2:0]  opt [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdata [2];
  logic        resp [2];
  logic        busy [2];
  logic        cs_n [2];
  logic        sck [2];
  logic        mosi [2];
  logic        miso [2] = '{1'b0, 1'b0};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_mem_bridge #(.ADDR_BYTES(3), .CLK_DIV(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .memory_read(mr[0]), .memory_write(mw[0]), .option(opt[0]),
    .address(addr[0]), .write_data(wdat[0]), .read_data(rdata[0]), .memory_response(resp[0]),
    .busy(busy[0]), .spi_cs_n(cs_n[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
  );

  spi_mem_bridge #(.ADDR_BYTES(2), .CLK_DIV(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .memory_read(mr[1]), .memory_write(mw[1]), .option(opt[1]),
    .address(addr[1]), .write_data(wdat[1]), .read_data(rdata[1]), .memory_response(resp[1]),
    .busy(busy[1]), .spi_cs_n(cs_n[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
  );

  // Serial SRAM model: captures MOSI bytes, serves READ data on MISO
  logic [7:0]  mem [2][65536];
  logic [7:0]  cap [2][16];
  int          bitc [2] = '{0, 0};
  logic [63:0] msh [2];
  logic        sck_prev [2] = '{1'b0, 1'b0};
  logic        cs_prev [2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int hdr;
      int rel;
      logic [15:0] a;
      logic [7:0]  b;
      hdr = (i == 0) ? 32 : 24;
      if (cs_prev[i] && !cs_n[i]) bitc[i] = 0;
      if (!cs_n[i]) begin
        if (sck[i] && !sck_prev[i]) begin
          msh[i] = {msh[i][62:0], mosi[i]};
          bitc[i] = bitc[i] + 1;
          if ((bitc[i] % 8) == 0 && bitc[i] <= 128) cap[i][bitc[i]/8 - 1] = msh[i][7:0];
        end else if (!sck[i] && sck_prev[i] && bitc[i] >= hdr && cap[i][0] == 8'h03) begin
          a = (i == 0) ? {cap[i][2], cap[i][3]} : {cap[i][1], cap[i][2]};
          rel = bitc[i] - hdr;
          b = mem[i][a + 16'(rel / 8)];
          miso[i] = b[7 - (rel % 8)];
        end
      end
      sck_prev[i] = sck[i];
      cs_prev[i]  = cs_n[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_access(input int inst, input bit rd, input bit wr, input logic [2:0] o,
                            input logic [31:0] a, input logic [31:0] wd,
                            output int lat, output int r1, output int r2,
                            output logic cs_at, output logic busy_at, output logic busy_after);
    int   rises;
    logic sp;
    @(negedge clk);
    mr[inst] = rd; mw[inst] = wr; opt[inst] = o; addr[inst] = a; wdat[inst] = wd;
    @(posedge clk);
    lat = -1; r1 = -1; r2 = -1; rises = 0; sp = 1'b0;
    cs_at = 1'bx; busy_at = 1'bx;
    for (int cnt = 1; cnt < 3000; cnt++) begin
      @(negedge clk);
      if (sck[inst] && !sp) begin
        rises++;
        if (rises == 1) r1 = cnt;
        if (rises == 2) r2 = cnt;
      end
      sp = sck[inst];
      if (resp[inst]) begin
        lat = cnt; cs_at = cs_n[inst]; busy_at = busy[inst];
        break;
      end
    end
    mr[inst] = 1'b0; mw[inst] = 1'b0;
    @(negedge clk);
    busy_after = busy[inst];
    @(negedge clk);
  endtask

  typedef struct {
    int          inst;
    bit          rd;
    bit          wr;
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rdata;
    int          nb;
    logic [63:0] bytes;
  } vec_t;

  vec_t v [11];

  initial begin
    int   lat, r1, r2, d, seen;
    logic cs_at, busy_at, busy_after;
    logic [63:0] got;

    v[0]  = '{0, 1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 129, 32'h0000_0000, 8, 64'h0200_0104_EFBE_ADDE};
    v[1]  = '{0, 1'b1, 1'b0, 3'b000, 32'h0000_0010, 32'h0,          81, 32'hFFFF_FF80, 5, 64'h0300_0010_0000_0000};
    v[2]  = '{0, 1'b1, 1'b0, 3'b100, 32'h0000_0010, 32'h0,          81, 32'h0000_0080, 5, 64'h0300_0010_0000_0000};
    v[3]  = '{0, 1'b1, 1'b1, 3'b000, 32'h0000_0020, 32'h1122_3355,  81, 32'h0000_0080, 5, 64'h0200_0020_5500_0000};
    v[4]  = '{1, 1'b1, 1'b0, 3'b001, 32'h0001_FFFE, 32'h0,         241, 32'hFFFF_9234, 5, 64'h03FF_FE00_0000_0000};
    v[5]  = '{0, 1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0,         129, 32'h1234_5678, 8, 64'h0300_0200_0000_0000};
    v[6]  = '{1, 1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,         241, 32'h0000_ABCD, 5, 64'h0301_0000_0000_0000};
    v[7]  = '{0, 1'b0, 1'b1, 3'b001, 32'h0000_0030, 32'hCAFE_1234,  97, 32'h1234_5678, 6, 64'h0200_0030_3412_0000};
    v[8]  = '{0, 1'b1, 1'b0, 3'b001, 32'h0000_0040, 32'h0,          97, 32'h0000_7122, 6, 64'h0300_0040_0000_0000};
    v[9]  = '{0, 1'b1, 1'b0, 3'b011, 32'h0000_0200, 32'h0,         129, 32'h1234_5678, 8, 64'h0300_0200_0000_0000};
    v[10] = '{1, 1'b1, 1'b0, 3'b000, 32'hABCD_0005, 32'h0,         193, 32'h0000_007F, 4, 64'h0300_0500_0000_0000};

    mem[0][16'h0010] = 8'h80;
    mem[0][16'h0200] = 8'h78; mem[0][16'h0201] = 8'h56;
    mem[0][16'h0202] = 8'h34; mem[0][16'h0203] = 8'h12;
    mem[0][16'h0040] = 8'h22; mem[0][16'h0041] = 8'h71;
    mem[1][16'hFFFE] = 8'h34; mem[1][16'hFFFF] = 8'h92;
    mem[1][16'h0100] = 8'hCD; mem[1][16'h0101] = 8'hAB;
    mem[1][16'h0005] = 8'h7F;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mr[i] = 1'b0; mw[i] = 1'b0; opt[i] = '0; addr[i] = '0; wdat[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs_n", 64'(cs_n[i]), 64'h1);
      chk("rst_sck", 64'(sck[i]), 64'h0);
      chk("rst_mosi", 64'(mosi[i]), 64'h0);
      chk("rst_busy", 64'(busy[i]), 64'h0);
      chk("rst_resp", 64'(resp[i]), 64'h0);
      chk("rst_rdata", 64'(rdata[i]), 64'h0);
    end

    // Reset during the address phase abandons the access with no response
    mr[0] = 1'b1; opt[0] = 3'b010; addr[0] = 32'h0000_0200;
    @(posedge clk);
    repeat (30) @(negedge clk);
    chk("mid_pre_cs_n", 64'(cs_n[0]), 64'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_cs_n", 64'(cs_n[0]), 64'h1);
    chk("mid_sck", 64'(sck[0]), 64'h0);
    chk("mid_busy", 64'(busy[0]), 64'h0);
    mr[0] = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp[0]) seen++;
    end
    rst_n = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (resp[0]) seen++;
    end
    chk("mid_no_resp", 64'(seen), 64'h0);

    for (int k = 0; k < 11; k++) begin
      d = (v[k].inst == 0) ? 1 : 3;
      run_access(v[k].inst, v[k].rd, v[k].wr, v[k].o, v[k].a, v[k].wd,
                 lat, r1, r2, cs_at, busy_at, busy_after);
      got = '0;
      for (int b = 0; b < bitc[v[k].inst] / 8 && b < 8; b++) got[63 - 8*b -: 8] = cap[v[k].inst][b];
      chk($sformatf("v%0d_latency", k), 64'(lat), 64'(v[k].lat));
      chk($sformatf("v%0d_read_data", k), 64'(rdata[v[k].inst]), 64'(v[k].rdata));
      chk($sformatf("v%0d_nbytes", k), 64'(bitc[v[k].inst] / 8), 64'(v[k].nb));
      chk($sformatf("v%0d_mosi", k), got, v[k].bytes);
      chk($sformatf("v%0d_cs_at_resp", k), 64'(cs_at), 64'h1);
      chk($sformatf("v%0d_busy_at_resp", k), 64'(busy_at), 64'h1);
      chk($sformatf("v%0d_busy_after", k), 64'(busy_after), 64'h0);
      chk($sformatf("v%0d_first_rise", k), 64'(r1), 64'(1 + d));
      chk($sformatf("v%0d_second_rise", k), 64'(r2), 64'(1 + 3*d));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
